otp_generator: RTL and testbench



---
 rtl/otp_generator.sv | 111 +++++++++++
 tb/tb_otp_generator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_generator.sv
// OTP source: free-running Galois LFSR sampled nibble-by-nibble into a four-digit BCD code.
// Define OTPGEN_MOD10_EN to use mod-10 folding instead of rejection sampling.
module otp_generator #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter logic [15:0] TAPS       = 16'hB400,
    parameter int unsigned REJECT_CAP = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gen_req,
    input  logic        entropy,
    output logic [15:0] lfsr_digit,
    output logic        lfsr_latch,
    output logic        busy
);
    // The all-zero state is a lock-up point for the LFSR, so it is never loaded.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    logic [0:0]  r_state;
    logic [15:0] r_lfsr;
    logic [1:0]  r_idx;
    logic [3:0]  r_slot0;
    logic [3:0]  r_slot1;
    logic [3:0]  r_slot2;

    logic        w_fb;
    logic [15:0] w_lfsr_step;
    logic [15:0] w_lfsr_next;
    logic [3:0]  w_nib;
    logic        w_accept;
    logic [3:0]  w_digit;

    assign w_fb        = r_lfsr[0] ^ entropy;
    assign w_lfsr_step = (r_lfsr >> 1) ^ (w_fb ? TAPS : 16'h0000);
    assign w_lfsr_next = (w_lfsr_step == 16'h0000) ? 16'h0001 : w_lfsr_step;
    assign w_nib       = r_lfsr[3:0];

`ifdef OTPGEN_MOD10_EN
    assign w_accept = 1'b1;
    assign w_digit  = (w_nib >= 4'd10) ? (w_nib - 4'd10) : w_nib;
`else
    localparam logic [3:0] CAP_M1 = 4'(REJECT_CAP - 1);

    logic [3:0] r_rej;

    // After CAP_M1 consecutive rejects the next nibble is folded into 4..9 so latency stays bounded.
    assign w_accept = (w_nib <= 4'd9) || (r_rej == CAP_M1);
    assign w_digit  = (w_nib <= 4'd9) ? w_nib : (w_nib - 4'd6);
`endif

    assign busy = (r_state == ST_COLLECT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_lfsr     <= SEED_EFF;
            r_idx      <= 2'd0;
            r_slot0    <= 4'd0;
            r_slot1    <= 4'd0;
            r_slot2    <= 4'd0;
            lfsr_digit <= 16'h0000;
            lfsr_latch <= 1'b0;
`ifndef OTPGEN_MOD10_EN
            r_rej      <= 4'd0;
`endif
        end else begin
            r_lfsr     <= w_lfsr_next;
            lfsr_latch <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (gen_req) begin
                        r_state <= ST_COLLECT;
                        r_idx   <= 2'd0;
`ifndef OTPGEN_MOD10_EN
                        r_rej   <= 4'd0;
`endif
                    end
                end
                ST_COLLECT: begin
                    if (w_accept) begin
`ifndef OTPGEN_MOD10_EN
                        r_rej <= 4'd0;
`endif
                        if (r_idx == 2'd3) begin
                            lfsr_digit <= {r_slot0, r_slot1, r_slot2, w_digit};
                            lfsr_latch <= 1'b1;
                            r_state    <= ST_IDLE;
                            r_idx      <= 2'd0;
                        end else begin
                            case (r_idx)
                                2'd0:    r_slot0 <= w_digit;
                                2'd1:    r_slot1 <= w_digit;
                                default: r_slot2 <= w_digit;
                            endcase
                            r_idx <= r_idx + 2'd1;
                        end
                    end
`ifndef OTPGEN_MOD10_EN
                    else begin
                        r_rej <= r_rej + 4'd1;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_otp_generator.sv
// Self-checking bench for otp_generator: directed vectors, reset mid-collection, back-to-back and a random soak
// checked against a nibble-list reference model.
module tb_otp_generator;
    localparam logic [15:0] SEED_A = 16'h0168;
    localparam logic [15:0] TAPS   = 16'hB400;
    localparam int          CAP    = 3;
`ifdef OTPGEN_MOD10_EN
    localparam logic [15:0] EXP_A      = 16'h4036;
    localparam int          EXP_EDGE_A = 5;
    localparam logic [15:0] EXP_PIN2   = 16'h0121;
`else
    localparam logic [15:0] EXP_A      = 16'h4652;
    localparam int          EXP_EDGE_A = 8;
    localparam logic [15:0] EXP_PIN2   = 16'h6123;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic gen_req = 1'b0;
    logic entropy = 1'b0;
    logic gen_req_z = 1'b0;
    logic [15:0] lfsr_digit, lfsr_digit_z;
    logic lfsr_latch, lfsr_latch_z, busy, busy_z;

    always #5 clk = ~clk;

    otp_generator #(.SEED(SEED_A), .TAPS(TAPS), .REJECT_CAP(CAP)) dut (
        .clk(clk), .reset(reset), .gen_req(gen_req), .entropy(entropy),
        .lfsr_digit(lfsr_digit), .lfsr_latch(lfsr_latch), .busy(busy));

    otp_generator #(.SEED(16'h0000)) dut_z (
        .clk(clk), .reset(reset), .gen_req(gen_req_z), .entropy(1'b0),
        .lfsr_digit(lfsr_digit_z), .lfsr_latch(lfsr_latch_z), .busy(busy_z));

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s, input logic e);
        logic [15:0] n;
        n = s >> 1;
        if (s[0] ^ e) n = n ^ TAPS;
        return (n == 16'h0000) ? 16'h0001 : n;
    endfunction

    // Applies the digit rule to the list of nibbles sampled so far; returns {done, code}.
    function automatic logic [16:0] decode(input logic [3:0] q[$]);
        int acc;
        int rej;
        logic [15:0] code;
        logic [3:0] d;
        bit take;
        acc = 0; rej = 0; code = 16'h0;
        foreach (q[i]) begin
`ifdef OTPGEN_MOD10_EN
            take = 1'b1;
            d = 4'(int'(q[i]) % 10);
`else
            take = 1'b0;
            d = 4'h0;
            if (int'(q[i]) < 10) begin
                take = 1'b1; d = q[i];
            end else if (rej == CAP - 1) begin
                take = 1'b1; d = 4'(int'(q[i]) - 6);
            end else begin
                rej++;
            end
`endif
            if (take) begin
                code = {code[11:0], d};
                acc++;
                rej = 0;
                if (acc == 4) return {1'b1, code};
            end
        end
        return {1'b0, 16'h0000};
    endfunction

    logic [15:0] m_s = SEED_A;
    bit          m_idle = 1'b1;
    logic [15:0] m_digit = 16'h0;
    logic        m_latch = 1'b0;
    logic        m_busy = 1'b0;
    logic [3:0]  m_nibs[$];
    int          m_deliv = 0;
    int          cyc = 0;
    int          dut_start = 0;
    int          last_latch = -1000;
    int          n_dut_latch = 0;
    logic        prev_busy = 1'b0;

    always @(posedge clk) begin
        logic [16:0] r;
        logic bcd_ok;
        int lat;
        if (!reset) begin
            m_s = SEED_A; m_idle = 1'b1; m_digit = 16'h0; m_latch = 1'b0; m_busy = 1'b0;
            m_nibs.delete();
        end else begin
            m_latch = 1'b0;
            if (m_idle) begin
                if (gen_req) begin
                    m_idle = 1'b0; m_busy = 1'b1; m_nibs.delete();
                end
            end else begin
                m_nibs.push_back(m_s[3:0]);
                r = decode(m_nibs);
                if (r[16]) begin
                    m_digit = r[15:0]; m_latch = 1'b1; m_idle = 1'b1; m_busy = 1'b0;
                    m_deliv++;
                end
            end
            m_s = lfsr_next(m_s, entropy);
        end
        cyc++;
        #1;
        check("cyc_busy", 32'(busy), 32'(m_busy));
        check("cyc_latch", 32'(lfsr_latch), 32'(m_latch));
        check("cyc_digit", 32'(lfsr_digit), 32'(m_digit));
        if (!reset) begin
            prev_busy = 1'b0;
            last_latch = -1000;
        end else begin
            if (busy && !prev_busy) dut_start = cyc;
            prev_busy = busy;
            if (lfsr_latch) begin
                n_dut_latch++;
                bcd_ok = 1'b1;
                for (int i = 0; i < 4; i++) if (lfsr_digit[4*i +: 4] > 4'd9) bcd_ok = 1'b0;
                check("latch_bcd", 32'(bcd_ok), 32'd1);
                lat = cyc - dut_start;
`ifdef OTPGEN_MOD10_EN
                check("latency_exact", 32'(lat), 32'd4);
`else
                check("latency_range", 32'((lat >= 4) && (lat <= 4 * CAP)), 32'd1);
`endif
                check("latch_spacing", 32'((cyc - last_latch) >= 4), 32'd1);
                last_latch = cyc;
            end
        end
    end

    // Releases reset with gen_req on both DUTs so that edge 1 samples it, then records delivery edges.
    task automatic run_basic(input string tag);
        int lat_a, lat_z, extra;
        logic [15:0] dig_a, dig_z;
        lat_a = -1; lat_z = -1; extra = 0; dig_a = 16'h0; dig_z = 16'h0;
        entropy = 1'b0;
        @(negedge clk);
        reset = 1'b1; gen_req = 1'b1; gen_req_z = 1'b1;
        @(negedge clk);
        gen_req = 1'b0; gen_req_z = 1'b0;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (lfsr_latch) begin
                if (lat_a < 0) begin lat_a = k; dig_a = lfsr_digit; end
                else extra++;
            end
            if (lfsr_latch_z) begin
                if (lat_z < 0) begin lat_z = k; dig_z = lfsr_digit_z; end
                else extra++;
            end
        end
        check({tag, "_edge"}, 32'(lat_a), 32'(EXP_EDGE_A));
        check({tag, "_code"}, 32'(dig_a), 32'(EXP_A));
        check({tag, "_zero_edge"}, 32'(lat_z), 32'd5);
        check({tag, "_zero_code"}, 32'(dig_z), 32'h0000);
        check({tag, "_single_pulse"}, 32'(extra), 32'd0);
    endtask

    initial begin
        logic [3:0] pq[$];
        logic [15:0] s;
        int cnt, zero_seen, d0, l0, budget;

        check("model_step0", 32'(lfsr_next(16'h0168, 1'b0)), 32'h00B4);
        check("model_step1", 32'(lfsr_next(16'h5A0B, 1'b0)), 32'h9905);
        check("model_guard", 32'(lfsr_next(16'h0001, 1'b1)), 32'h0001);
        pq = '{4'h4, 4'hA, 4'hD, 4'h6, 4'hB, 4'h5, 4'h2};
        check("model_decode_a", 32'(decode(pq)), 32'({1'b1, EXP_A}));
        pq = '{4'hA, 4'hB, 4'hC, 4'h1, 4'h2, 4'h3};
        check("model_decode_cap", 32'(decode(pq)), 32'({1'b1, EXP_PIN2}));
        s = 16'h0001; cnt = 0; zero_seen = 0;
        do begin
            s = lfsr_next(s, 1'b0);
            cnt++;
            if (s == 16'h0000) zero_seen++;
        end while (s != 16'h0001 && cnt < 70000);
        check("model_period", 32'(cnt), 32'd65535);
        check("model_no_zero", 32'(zero_seen), 32'd0);

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_digit", 32'(lfsr_digit), 32'h0);
        check("rst_latch", 32'(lfsr_latch), 32'd0);
        check("rst_busy_z", 32'(busy_z), 32'd0);

        run_basic("basic");

        // Reset two cycles into a collection: outputs clear at once, then the first result reproduces.
        @(negedge clk);
        gen_req = 1'b1;
        @(negedge clk);
        gen_req = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_digit", 32'(lfsr_digit), 32'h0);
        check("midrst_latch", 32'(lfsr_latch), 32'd0);
        repeat (2) @(negedge clk);
        run_basic("rerun");

        // gen_req held high: deliveries back to back with random entropy.
        d0 = m_deliv; l0 = n_dut_latch;
        gen_req = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            entropy = 1'($urandom_range(0, 1));
        end
        gen_req = 1'b0;
        check("b2b_some_deliveries", 32'((m_deliv - d0) >= 5), 32'd1);

        // Random soak: gen_req toggles freely, including while busy.
        d0 = m_deliv; l0 = n_dut_latch; budget = 0;
        while ((m_deliv - d0) < 2000 && budget < 40000) begin
            @(negedge clk);
            gen_req = 1'($urandom_range(0, 1));
            entropy = 1'($urandom_range(0, 1));
            budget++;
        end
        gen_req = 1'b0;
        entropy = 1'b0;
        check("soak_model_count", 32'((m_deliv - d0) >= 2000), 32'd1);
        check("soak_dut_count", 32'(n_dut_latch - l0), 32'(m_deliv - d0));

        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule
